// File: rtl/color_proc_sched.sv
// Frame scheduler for the color filter datapath: one processing pass per captured frame,
// ping-pong processed banks, filter selection latched only at frame start.
module color_proc_sched #(
  parameter int C_IMG_PXLS    = 76800,
  parameter int C_NB_IMG_PXLS = 17,
  parameter int C_NB_FCNT     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cam_frame_done,
  input  logic                     filt_next,
  output logic [C_NB_IMG_PXLS-1:0] orig_addr,
  output logic [C_NB_IMG_PXLS-1:0] proc_addr,
  output logic                     proc_we,
  output logic                     proc_bank,
  output logic                     disp_bank,
  output logic [2:0]               filt_sel,
  output logic                     proc_busy,
  output logic [C_NB_FCNT-1:0]     frame_cnt,
  output logic                     overrun
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, SWAP} state_t;

  localparam logic [C_NB_IMG_PXLS-1:0] LAST_ADDR = C_NB_IMG_PXLS'(C_IMG_PXLS - 1);

  state_t     state, state_nxt;
  logic       pend_frame;
  logic [2:0] pend_filt;
  logic       filt_s1, filt_s2, filt_s3;
  logic       filt_edge;
  logic       start;
  logic       last_pxl;

  assign filt_edge = filt_s2 & ~filt_s3;
  assign start     = (state == IDLE) && (cam_frame_done || pend_frame);
  assign last_pxl  = (orig_addr == LAST_ADDR);
  assign proc_busy = (state != IDLE);

  function automatic logic [2:0] next_filt(input logic [2:0] f);
    case (f)
      3'b000:  next_filt = 3'b100;
      3'b100:  next_filt = 3'b010;
      3'b010:  next_filt = 3'b001;
      3'b001:  next_filt = 3'b110;
      3'b110:  next_filt = 3'b101;
      3'b101:  next_filt = 3'b011;
      3'b011:  next_filt = 3'b111;
      default: next_filt = 3'b000;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_pxl) state_nxt = FLUSH;
      FLUSH:   state_nxt = SWAP;
      SWAP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read side counter doubles as orig_addr; it parks on the last pixel after RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      orig_addr <= '0;
      filt_sel  <= 3'b000;
    end else if (start) begin
      orig_addr <= '0;
      filt_sel  <= pend_filt;
    end else if (state == RUN && !last_pxl) begin
      orig_addr <= orig_addr + C_NB_IMG_PXLS'(1);
    end
  end

  // Write side trails the read by the one-cycle memory latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      proc_we   <= 1'b0;
      proc_addr <= '0;
    end else begin
      proc_we <= (state == RUN);
      if (state == RUN) proc_addr <= orig_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      proc_bank <= 1'b0;
      disp_bank <= 1'b1;
      frame_cnt <= '0;
    end else if (state == SWAP) begin
      proc_bank <= ~proc_bank;
      disp_bank <= proc_bank;
      frame_cnt <= frame_cnt + C_NB_FCNT'(1);
    end
  end

  // One frame may queue behind the active pass; a second one is dropped and flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_frame <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (state == IDLE) begin
        if (start) pend_frame <= pend_frame & cam_frame_done;
      end else if (cam_frame_done) begin
        if (!pend_frame) pend_frame <= 1'b1;
        else             overrun    <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_s1   <= 1'b0;
      filt_s2   <= 1'b0;
      filt_s3   <= 1'b0;
      pend_filt <= 3'b000;
    end else begin
      filt_s1 <= filt_next;
      filt_s2 <= filt_s1;
      filt_s3 <= filt_s2;
      if (filt_edge) pend_filt <= next_filt(pend_filt);
    end
  end

endmodule
